// File: rtl/haz_resolver_pl_pkg.sv
// rtl/haz_resolver_pl_pkg.sv - shared types and helpers for the hazard resolver
//
// Purpose : FSM state enum, front-end stall mask and counter-width helper
//           used by haz_resolver_pl and haz_lat_counter.
// Ports   : none (package).
package haz_pkg;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    CTRL_WAIT  = 3'd1,
    LOAD_STALL = 3'd2,
    STR_STALL  = 3'd3,
    FLUSH      = 3'd4
  } haz_state_t;

  // Stages IF and ID are held for data and structural hazards.
  localparam logic [1:0] HAZ_STALL_FE = 2'b11;

  // Wide enough to hold the largest load value and the watchdog saturation point.
  function automatic int haz_cnt_w(input int load_lat, input int flush_cyc, input int tmo_cyc);
    int m;
    m = load_lat;
    if (flush_cyc > m) m = flush_cyc;
    if (tmo_cyc > m) m = tmo_cyc;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/haz_lat_counter.sv
// rtl/haz_lat_counter.sv - shared load/decrement/up-count latency counter
//
// Purpose : one counter reused by every timed state of the hazard resolver.
//           Load has priority, decrement saturates at 0, up-count saturates
//           at LIMIT.
// Ports   : clk, rst_n      clock, synchronous active-low reset
//           i_load/i_load_val  load a new value (state entry)
//           i_dec          count down toward 0
//           i_inc          count up toward LIMIT
//           o_zero         counter is 0
//           o_lim          counter is LIMIT-1 (watchdog expiry)
module haz_lat_counter #(
  parameter int W     = 5,
  parameter int LIMIT = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_dec,
  input  logic         i_inc,
  output logic         o_zero,
  output logic         o_lim
);

  localparam logic [W-1:0] ONE    = W'(1);
  localparam logic [W-1:0] LIM    = W'(LIMIT);
  localparam logic [W-1:0] LIM_M1 = W'(LIMIT - 1);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - ONE;
    end else if (i_inc && (r_cnt != LIM)) begin
      r_cnt <= r_cnt + ONE;
    end
  end

  assign o_zero = (r_cnt == '0);
  assign o_lim  = (r_cnt == LIM_M1);

endmodule

// File: rtl/haz_resolver_pl.sv
// rtl/haz_resolver_pl.sv - issue-stage pipeline hazard resolver
//
// Purpose : classifies control, load-use and structural hazards, holds each
//           for its configured time and drives per-stage stall/flush vectors,
//           PC freeze and a sticky watchdog error.
// Ports   : clk, rst_n            clock, synchronous active-low reset
//           data_haz, fwd_ok      load-use dependency / forwarding covers it
//           str_haz               structural conflict
//           ctrl_haz              branch in flight
//           br_resolved           branch outcome valid
//           br_mispredict         outcome is wrong-path (with br_resolved)
//           pc_freeze             hold PC
//           stall_vec/flush_vec   per-stage hold / squash (NSTAGE bits)
//           do_flush              redirect/flush strobe
//           resolved              no hazard active
//           tmo_err               sticky watchdog error
//           stall_cycles, flush_events  32-bit perf counters (HAZ_PERF_CNT_EN)
// Config  : define HAZ_PERF_CNT_EN to add the performance counters.
module haz_resolver_pl
  import haz_pkg::*;
#(
  parameter int NSTAGE      = 5,
  parameter int LOAD_LAT    = 2,
  parameter int FLUSH_CYC   = 1,
  parameter int FLUSH_DEPTH = 2,
  parameter int TMO_CYC     = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              data_haz,
  input  logic              fwd_ok,
  input  logic              str_haz,
  input  logic              ctrl_haz,
  input  logic              br_resolved,
  input  logic              br_mispredict,
  output logic              pc_freeze,
  output logic [NSTAGE-1:0] stall_vec,
  output logic [NSTAGE-1:0] flush_vec,
  output logic              do_flush,
  output logic              resolved,
  output logic              tmo_err
`ifdef HAZ_PERF_CNT_EN
  ,
  output logic [31:0]       stall_cycles,
  output logic [31:0]       flush_events
`endif
);

  localparam int CW = haz_cnt_w(LOAD_LAT, FLUSH_CYC, TMO_CYC);
  localparam logic [CW-1:0] LD_INIT = CW'(LOAD_LAT - 1);
  localparam logic [CW-1:0] FL_INIT = CW'(FLUSH_CYC - 1);

  haz_state_t    r_state;
  logic          r_tmo_err;

  haz_state_t    w_nxt;
  logic          w_load;
  logic [CW-1:0] w_load_val;
  logic          w_dec;
  logic          w_inc;
  logic          w_set_tmo;
  logic          w_use_prio;
  logic          w_skip_ctrl;
  logic          w_zero;
  logic          w_lim;
  logic          w_mispred;

  assign w_mispred = br_resolved & br_mispredict;

  haz_lat_counter #(
    .W     (CW),
    .LIMIT (TMO_CYC)
  ) u_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .i_dec      (w_dec),
    .i_inc      (w_inc),
    .o_zero     (w_zero),
    .o_lim      (w_lim)
  );

  // Next state and counter control. Every state change (and the re-entry of
  // LOAD_STALL on a persisting hazard) goes through a load so each timed
  // state starts from a known count.
  always_comb begin
    w_nxt       = r_state;
    w_load      = 1'b0;
    w_load_val  = '0;
    w_dec       = 1'b0;
    w_inc       = 1'b0;
    w_set_tmo   = 1'b0;
    w_use_prio  = 1'b0;
    w_skip_ctrl = 1'b0;

    case (r_state)
      IDLE: begin
        w_use_prio = 1'b1;
      end
      CTRL_WAIT: begin
        if (w_mispred) begin
          w_nxt      = FLUSH;
          w_load     = 1'b1;
          w_load_val = FL_INIT;
        end else if (br_resolved) begin
          // The branch that raised ctrl_haz is done; a stale ctrl_haz this
          // cycle must not bounce straight back into CTRL_WAIT.
          w_use_prio  = 1'b1;
          w_skip_ctrl = 1'b1;
        end else if (w_lim) begin
          w_nxt      = FLUSH;
          w_load     = 1'b1;
          w_load_val = FL_INIT;
          w_set_tmo  = 1'b1;
        end else begin
          w_inc = 1'b1;
        end
      end
      LOAD_STALL: begin
        if (fwd_ok || !data_haz || w_zero) begin
          w_use_prio = 1'b1;
        end else begin
          w_dec = 1'b1;
        end
      end
      STR_STALL: begin
        if (w_mispred) begin
          w_nxt      = FLUSH;
          w_load     = 1'b1;
          w_load_val = FL_INIT;
        end else if (!str_haz) begin
          w_use_prio = 1'b1;
        end else if (w_lim) begin
          w_nxt     = IDLE;
          w_load    = 1'b1;
          w_set_tmo = 1'b1;
        end else begin
          w_inc = 1'b1;
        end
      end
      FLUSH: begin
        if (w_zero) begin
          w_use_prio = 1'b1;
        end else begin
          w_dec = 1'b1;
        end
      end
      default: begin
        w_nxt  = IDLE;
        w_load = 1'b1;
      end
    endcase

    if (w_use_prio) begin
      w_load = 1'b1;
      w_dec  = 1'b0;
      w_inc  = 1'b0;
      if (ctrl_haz && !w_skip_ctrl) begin
        w_nxt = CTRL_WAIT;
      end else if (data_haz && !fwd_ok) begin
        w_nxt      = LOAD_STALL;
        w_load_val = LD_INIT;
      end else if (str_haz) begin
        w_nxt = STR_STALL;
      end else begin
        w_nxt = IDLE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_tmo_err <= 1'b0;
    end else begin
      r_state <= w_nxt;
      if (w_set_tmo) begin
        r_tmo_err <= 1'b1;
      end
    end
  end

  // Moore output decode; unknown encodings look like IDLE for their one cycle.
  always_comb begin
    resolved  = 1'b0;
    pc_freeze = 1'b0;
    do_flush  = 1'b0;
    stall_vec = '0;
    flush_vec = '0;
    case (r_state)
      IDLE: begin
        resolved = 1'b1;
      end
      CTRL_WAIT: begin
        pc_freeze    = 1'b1;
        stall_vec[0] = 1'b1;
      end
      LOAD_STALL, STR_STALL: begin
        pc_freeze      = 1'b1;
        stall_vec[1:0] = HAZ_STALL_FE;
      end
      FLUSH: begin
        pc_freeze = 1'b1;
        do_flush  = 1'b1;
        for (int i = 0; i < NSTAGE; i++) begin
          flush_vec[i] = (i < FLUSH_DEPTH);
        end
      end
      default: begin
        resolved = 1'b1;
      end
    endcase
  end

  assign tmo_err = r_tmo_err;

`ifdef HAZ_PERF_CNT_EN
  logic [31:0] r_stall_cycles;
  logic [31:0] r_flush_events;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_stall_cycles <= '0;
      r_flush_events <= '0;
    end else begin
      if (pc_freeze) begin
        r_stall_cycles <= r_stall_cycles + 32'd1;
      end
      if ((w_nxt == FLUSH) && (r_state != FLUSH)) begin
        r_flush_events <= r_flush_events + 32'd1;
      end
    end
  end

  assign stall_cycles = r_stall_cycles;
  assign flush_events = r_flush_events;
`endif

endmodule

// File: tb/tb_haz_resolver_pl.sv
// tb/tb_haz_resolver_pl.sv - scoreboard bench for haz_resolver_pl
module tb_haz_resolver_pl;

  localparam int NST  = 5;
  localparam int FD   = 2;
  localparam int TMO  = 16;
  localparam int LL_A = 2;
  localparam int FC_A = 1;
  localparam int LL_B = 3;
  localparam int FC_B = 2;

  localparam int M_IDLE = 0;
  localparam int M_BR   = 1;
  localparam int M_LD   = 2;
  localparam int M_ST   = 3;
  localparam int M_FL   = 4;

  typedef struct packed {
    logic [13:0] o;
    logic [31:0] sc;
    logic [31:0] fe;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic data_haz = 1'b0, fwd_ok = 1'b0, str_haz = 1'b0, ctrl_haz = 1'b0;
  logic br_resolved = 1'b0, br_mispredict = 1'b0;

  logic           a_pc_freeze, a_do_flush, a_resolved, a_tmo_err;
  logic [NST-1:0] a_stall_vec, a_flush_vec;
  logic           b_pc_freeze, b_do_flush, b_resolved, b_tmo_err;
  logic [NST-1:0] b_stall_vec, b_flush_vec;
`ifdef HAZ_PERF_CNT_EN
  logic [31:0] a_sc, a_fe, b_sc, b_fe;
`endif

  always #5 clk = ~clk;

  haz_resolver_pl #(.NSTAGE(NST), .LOAD_LAT(LL_A), .FLUSH_CYC(FC_A), .FLUSH_DEPTH(FD), .TMO_CYC(TMO)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .data_haz(data_haz), .fwd_ok(fwd_ok), .str_haz(str_haz),
    .ctrl_haz(ctrl_haz), .br_resolved(br_resolved), .br_mispredict(br_mispredict),
    .pc_freeze(a_pc_freeze), .stall_vec(a_stall_vec), .flush_vec(a_flush_vec),
    .do_flush(a_do_flush), .resolved(a_resolved), .tmo_err(a_tmo_err)
`ifdef HAZ_PERF_CNT_EN
    , .stall_cycles(a_sc), .flush_events(a_fe)
`endif
  );

  haz_resolver_pl #(.NSTAGE(NST), .LOAD_LAT(LL_B), .FLUSH_CYC(FC_B), .FLUSH_DEPTH(FD), .TMO_CYC(TMO)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .data_haz(data_haz), .fwd_ok(fwd_ok), .str_haz(str_haz),
    .ctrl_haz(ctrl_haz), .br_resolved(br_resolved), .br_mispredict(br_mispredict),
    .pc_freeze(b_pc_freeze), .stall_vec(b_stall_vec), .flush_vec(b_flush_vec),
    .do_flush(b_do_flush), .resolved(b_resolved), .tmo_err(b_tmo_err)
`ifdef HAZ_PERF_CNT_EN
    , .stall_cycles(b_sc), .flush_events(b_fe)
`endif
  );

  // Reference model: mode plus "cycles left" (timed stalls) or "cycles spent"
  // (watchdog waits), one copy per instance.
  int          md[2];
  int          age[2];
  int          left[2];
  logic        tmo[2];
  logic [31:0] sc[2];
  logic [31:0] fe[2];

  exp_t q_a[$];
  exp_t q_b[$];

  int n_chk = 0;
  int n_pass = 0;

  function automatic int ll(int k);
    return (k == 0) ? LL_A : LL_B;
  endfunction

  function automatic int fc(int k);
    return (k == 0) ? FC_A : FC_B;
  endfunction

  task automatic enter(int k, int m);
    md[k]   = m;
    age[k]  = 0;
    left[k] = (m == M_LD) ? ll(k) : ((m == M_FL) ? fc(k) : 0);
    if (m == M_FL) fe[k] = fe[k] + 32'd1;
  endtask

  task automatic enter_prio(int k, bit skip_ctrl);
    if (ctrl_haz && !skip_ctrl) enter(k, M_BR);
    else if (data_haz && !fwd_ok) enter(k, M_LD);
    else if (str_haz) enter(k, M_ST);
    else enter(k, M_IDLE);
  endtask

  task automatic step(int k);
    bit mis;
    mis = br_resolved && br_mispredict;
    if (!rst_n) begin
      md[k] = M_IDLE; age[k] = 0; left[k] = 0;
      tmo[k] = 1'b0; sc[k] = '0; fe[k] = '0;
    end else begin
      if (md[k] != M_IDLE) sc[k] = sc[k] + 32'd1;
      case (md[k])
        M_BR: begin
          if (mis) enter(k, M_FL);
          else if (br_resolved) enter_prio(k, 1'b1);
          else if (age[k] == TMO - 1) begin enter(k, M_FL); tmo[k] = 1'b1; end
          else age[k]++;
        end
        M_LD: begin
          if (fwd_ok || !data_haz || left[k] == 1) enter_prio(k, 1'b0);
          else left[k]--;
        end
        M_ST: begin
          if (mis) enter(k, M_FL);
          else if (!str_haz) enter_prio(k, 1'b0);
          else if (age[k] == TMO - 1) begin enter(k, M_IDLE); tmo[k] = 1'b1; end
          else age[k]++;
        end
        M_FL: begin
          if (left[k] == 1) enter_prio(k, 1'b0);
          else left[k]--;
        end
        default: enter_prio(k, 1'b0);
      endcase
    end
  endtask

  function automatic exp_t expected(int k);
    exp_t e;
    logic [4:0] sv;
    logic [4:0] fv;
    sv = 5'b0;
    fv = 5'b0;
    if (md[k] == M_BR) sv = 5'b00001;
    if (md[k] == M_LD || md[k] == M_ST) sv = 5'b00011;
    if (md[k] == M_FL) for (int i = 0; i < FD; i++) fv[i] = 1'b1;
    e.o  = {md[k] == M_IDLE, md[k] != M_IDLE, md[k] == M_FL, tmo[k], sv, fv};
    e.sc = sc[k];
    e.fe = fe[k];
    return e;
  endfunction

  always @(posedge clk) begin
    step(0);
    q_a.push_back(expected(0));
    step(1);
    q_b.push_back(expected(1));
  end

  task automatic cmp(string nm, logic [31:0] act, logic [31:0] ex);
    n_chk++;
    if (act === ex) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, ex, $time);
  endtask

  // Monitor: outputs are valid every cycle, so one pop per instance per cycle.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q_a.size() == 0) begin
        n_chk++;
        $display("FAIL outs_a: got no expectation queued at %0t", $time);
      end else begin
        e = q_a.pop_front();
        cmp("outs_a", 32'({a_resolved, a_pc_freeze, a_do_flush, a_tmo_err, a_stall_vec, a_flush_vec}), 32'(e.o));
`ifdef HAZ_PERF_CNT_EN
        cmp("stall_cycles_a", a_sc, e.sc);
        cmp("flush_events_a", a_fe, e.fe);
`endif
      end
      if (q_b.size() == 0) begin
        n_chk++;
        $display("FAIL outs_b: got no expectation queued at %0t", $time);
      end else begin
        e = q_b.pop_front();
        cmp("outs_b", 32'({b_resolved, b_pc_freeze, b_do_flush, b_tmo_err, b_stall_vec, b_flush_vec}), 32'(e.o));
`ifdef HAZ_PERF_CNT_EN
        cmp("stall_cycles_b", b_sc, e.sc);
        cmp("flush_events_b", b_fe, e.fe);
`endif
      end
    end
  end

  task automatic drv(bit rs, bit dh, bit fw, bit sh, bit ch, bit brr, bit mis, int n);
    repeat (n) begin
      @(negedge clk);
      rst_n = rs; data_haz = dh; fwd_ok = fw; str_haz = sh;
      ctrl_haz = ch; br_resolved = brr; br_mispredict = mis;
    end
  endtask

  initial begin
    //  rs dh fw sh ch brr mis n
    drv(0, 0, 0, 0, 0, 0, 0, 2);   // reset
    drv(1, 0, 0, 0, 0, 0, 0, 2);
    drv(1, 1, 0, 0, 0, 0, 0, 4);   // load-use held 4 cycles
    drv(1, 0, 0, 0, 0, 0, 0, 3);
    drv(1, 1, 0, 0, 0, 0, 0, 2);   // forwarding appears mid-stall
    drv(1, 1, 1, 0, 0, 0, 0, 1);
    drv(1, 0, 0, 0, 0, 0, 0, 3);
    drv(1, 0, 0, 0, 1, 0, 0, 3);   // branch, mispredict after 3 cycles
    drv(1, 0, 0, 0, 0, 1, 1, 1);
    drv(1, 0, 0, 0, 0, 0, 0, 4);
    drv(1, 1, 0, 1, 1, 0, 0, 2);   // all three hazards, correct prediction
    drv(1, 1, 0, 1, 1, 1, 0, 1);
    drv(1, 1, 0, 1, 0, 0, 0, 3);
    drv(1, 0, 0, 1, 0, 0, 0, 3);
    drv(1, 0, 0, 0, 0, 0, 0, 3);
    drv(1, 0, 0, 0, 0, 1, 1, 2);   // resolution outside CTRL_WAIT ignored
    drv(1, 0, 0, 0, 1, 0, 1, 2);   // mispredict without resolved ignored
    drv(1, 0, 0, 0, 0, 1, 0, 1);
    drv(1, 0, 0, 1, 0, 0, 0, 20);  // structural watchdog
    drv(1, 0, 0, 0, 0, 0, 0, 3);
    drv(0, 0, 0, 0, 0, 0, 0, 1);   // clear sticky error
    drv(1, 0, 0, 0, 1, 0, 0, 18);  // branch watchdog
    drv(1, 0, 0, 0, 0, 0, 0, 3);
    drv(1, 0, 0, 1, 0, 0, 0, 3);   // mispredict during STR_STALL
    drv(1, 0, 0, 1, 0, 1, 1, 1);
    drv(1, 0, 0, 0, 0, 0, 0, 3);
    drv(1, 0, 0, 0, 1, 0, 0, 2);   // reset while in FLUSH
    drv(1, 0, 0, 0, 0, 1, 1, 1);
    drv(0, 0, 0, 0, 0, 0, 0, 1);
    drv(1, 0, 0, 0, 0, 0, 0, 3);
    repeat (3000) begin
      drv(($urandom % 300) != 0, ($urandom % 3) == 0, ($urandom % 2) == 0,
          ($urandom % 4) == 0, ($urandom % 6) == 0, ($urandom % 4) == 0,
          ($urandom % 2) == 0, $urandom_range(1, 3));
    end
    drv(1, 0, 0, 0, 0, 0, 0, 3);
    @(posedge clk);
    #2;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
